// File: rtl/ft601_pkg.sv
// ---------------------------------------------------------------------------
// ft601_pkg
// Shared types and constants for the FT601 bus responder.
//   FT601_DATA_W / FT601_BE_W : bus data and byte-enable widths
//   FT601_WORD_W              : width of one FIFO entry {be, data}
//   bus_state_e               : bus-side protocol state
//   sat_inc()                 : 8-bit saturating increment for error counters
// ---------------------------------------------------------------------------
package ft601_pkg;

    localparam int FT601_DATA_W = 32;
    localparam int FT601_BE_W   = 4;
    localparam int FT601_WORD_W = FT601_DATA_W + FT601_BE_W;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_RD_ARM   = 2'd1,
        ST_RD_BURST = 2'd2,
        ST_WR_BURST = 2'd3
    } bus_state_e;

    // Error counters stick at all-ones instead of wrapping back to zero.
    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/ft601_resp_fifo.sv
// ---------------------------------------------------------------------------
// ft601_resp_fifo
// First-word-fall-through FIFO used for both directions of the responder.
//   clk, rst        : clock, asynchronous active-high reset
//   flush           : synchronous clear (pointers and count to zero)
//   push, wr_data   : write request; ignored when full (even with a pop)
//   pop             : consume head entry; ignored when empty
//   rd_data         : head entry while not empty, otherwise zero
//   empty, full     : decoded directly from the registered count
// Parameters: DEPTH (power of two, >= 4), WIDTH (entry width).
// ---------------------------------------------------------------------------
module ft601_resp_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 36
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             pop,
    output logic [WIDTH-1:0] rd_data,
    output logic             empty,
    output logic             full
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q,  count_d;
    logic             push_ok, pop_ok;

    assign empty   = (count_q == '0);
    assign full    = (count_q == CW'(DEPTH));
    // A push at full is refused even if a pop frees a slot on the same edge.
    assign push_ok = push & ~full;
    assign pop_ok  = pop & ~empty;
    assign rd_data = empty ? '0 : mem_q[rd_ptr_q];

    // NOTE: every always_comb output gets a default first so no path leaves
    // it unassigned; a missing default would infer a latch.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            // Pointers are exactly AW bits wide, so they wrap modulo DEPTH.
            if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
            if (pop_ok)  rd_ptr_d = rd_ptr_q + AW'(1);
            case ({push_ok, pop_ok})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // NOTE: the storage array has no reset; stale entries are never visible
    // because rd_data is forced to zero while the count says empty.
    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= wr_data;
    end

endmodule

// File: rtl/ft601_bus_responder.sv
// ---------------------------------------------------------------------------
// ft601_bus_responder
// Responder side of an FT601-style 32-bit FIFO bus. Host words queue in the
// RX FIFO and are read out by the bus controller; controller writes queue in
// the TX FIFO and are drained by the host.
//   clk, rst                          : clock, async active-high reset
//   usb_wren_l/rden_l/outen_l         : controller strobes (active-low)
//   usb_rst_l                         : synchronous flush (active-low)
//   bus_in/be_in, bus_out/be_out      : bus write / read data
//   bus_oe                            : responder drives bus_out/be_out
//   usb_tx_full, usb_rx_empty         : FIFO flags towards the controller
//   host_tx_*                         : host -> RX FIFO (valid/ready)
//   host_rx_*                         : TX FIFO -> host (valid/ready)
//   proto_err, ovf_cnt, unf_cnt       : protocol error, error counters
// Build option: define FT601_RESP_CHECK_EN to include the protocol checker;
// otherwise proto_err is tied low.
// ---------------------------------------------------------------------------
module ft601_bus_responder
    import ft601_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    output logic                    usb_tx_full,
    output logic                    usb_rx_empty,
    input  logic                    usb_wren_l,
    input  logic                    usb_rden_l,
    input  logic                    usb_outen_l,
    input  logic                    usb_rst_l,
    input  logic [FT601_DATA_W-1:0] bus_in,
    input  logic [FT601_BE_W-1:0]   be_in,
    output logic [FT601_DATA_W-1:0] bus_out,
    output logic [FT601_BE_W-1:0]   be_out,
    output logic                    bus_oe,
    input  logic [FT601_DATA_W-1:0] host_tx_data,
    input  logic [FT601_BE_W-1:0]   host_tx_be,
    input  logic                    host_tx_valid,
    output logic                    host_tx_ready,
    output logic [FT601_DATA_W-1:0] host_rx_data,
    output logic [FT601_BE_W-1:0]   host_rx_be,
    output logic                    host_rx_valid,
    input  logic                    host_rx_ready,
    output logic                    proto_err,
    output logic [7:0]              ovf_cnt,
    output logic [7:0]              unf_cnt
);

    logic                    flush;
    logic                    rx_empty, rx_full, tx_empty, tx_full;
    logic [FT601_WORD_W-1:0] rx_head, tx_head;
    logic                    bus_read, bus_write;
    logic [7:0]              ovf_cnt_q, ovf_cnt_d;
    logic [7:0]              unf_cnt_q, unf_cnt_d;
    bus_state_e              state_q;

    assign flush     = ~usb_rst_l;
    assign bus_read  = ~usb_rden_l & ~usb_outen_l;
    assign bus_write = ~usb_wren_l;

    // Host handshakes are withheld during a flush cycle so no word is
    // reported as transferred and then thrown away.
    assign host_tx_ready = ~rx_full & usb_rst_l;
    assign host_rx_valid = ~tx_empty & usb_rst_l;

    ft601_resp_fifo #(.DEPTH(DEPTH), .WIDTH(FT601_WORD_W)) u_rx_fifo (
        .clk     (clk),
        .rst     (rst),
        .flush   (flush),
        .push    (host_tx_valid & host_tx_ready),
        .wr_data ({host_tx_be, host_tx_data}),
        .pop     (bus_read),
        .rd_data (rx_head),
        .empty   (rx_empty),
        .full    (rx_full)
    );

    ft601_resp_fifo #(.DEPTH(DEPTH), .WIDTH(FT601_WORD_W)) u_tx_fifo (
        .clk     (clk),
        .rst     (rst),
        .flush   (flush),
        .push    (bus_write),
        .wr_data ({be_in, bus_in}),
        .pop     (host_rx_valid & host_rx_ready),
        .rd_data (tx_head),
        .empty   (tx_empty),
        .full    (tx_full)
    );

    assign {be_out, bus_out}         = rx_head;
    assign {host_rx_be, host_rx_data} = tx_head;
    assign usb_rx_empty              = rx_empty;
    assign usb_tx_full               = tx_full;
    // The controller owns the bus whenever it is writing.
    assign bus_oe                    = ~usb_outen_l & usb_wren_l;

    // Overflow: write strobe against a full TX FIFO (word dropped).
    // Underflow: read strobe against an empty RX FIFO (no pop).
    always_comb begin
        ovf_cnt_d = ovf_cnt_q;
        unf_cnt_d = unf_cnt_q;
        if (flush) begin
            ovf_cnt_d = '0;
            unf_cnt_d = '0;
        end else begin
            if (bus_write && tx_full)   ovf_cnt_d = sat_inc(ovf_cnt_q);
            if (!usb_rden_l && rx_empty) unf_cnt_d = sat_inc(unf_cnt_q);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf_cnt_q <= '0;
            unf_cnt_q <= '0;
        end else begin
            ovf_cnt_q <= ovf_cnt_d;
            unf_cnt_q <= unf_cnt_d;
        end
    end

    assign ovf_cnt = ovf_cnt_q;
    assign unf_cnt = unf_cnt_q;

    // Bus protocol tracker. An OE-only cycle arms a read; a read burst ends
    // as soon as either strobe rises; a write burst that ends with OE already
    // low goes straight to the armed-read state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else if (flush) begin
            state_q <= ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (!usb_wren_l)                     state_q <= ST_WR_BURST;
                    else if (!usb_outen_l && usb_rden_l) state_q <= ST_RD_ARM;
                end
                ST_RD_ARM: begin
                    if (usb_outen_l)      state_q <= ST_IDLE;
                    else if (!usb_rden_l) state_q <= ST_RD_BURST;
                end
                ST_RD_BURST: begin
                    if (usb_outen_l || usb_rden_l) state_q <= ST_IDLE;
                end
                ST_WR_BURST: begin
                    if (usb_wren_l) state_q <= usb_outen_l ? ST_IDLE : ST_RD_ARM;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

`ifdef FT601_RESP_CHECK_EN
    logic proto_err_q, proto_err_d;
    logic proto_viol;

    // Violations: a read strobe with no OE preamble, or a write while the
    // controller also asks the responder to drive the bus.
    always_comb begin
        proto_viol  = ((state_q == ST_IDLE) && !usb_rden_l) ||
                      (!usb_wren_l && !usb_outen_l);
        proto_err_d = flush ? 1'b0 : (proto_err_q | proto_viol);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) proto_err_q <= 1'b0;
        else     proto_err_q <= proto_err_d;
    end

    assign proto_err = proto_err_q;
`else
    assign proto_err = 1'b0;
`endif

endmodule
